// File: rtl/comparator_seq.sv
// Purpose : multi-cycle magnitude comparator, CHUNK bits per cycle, MSB chunk first, early exit on first differing chunk.
// Latency : done pulses in the cycle after edge k+m (m = chunks examined, 1..NCHUNK); ready returns at edge k+m+1.
// Backpr. : start is only accepted while ready=1; requests during RUN/DONE are dropped, nothing is queued.
module comparator_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             ready,
    output logic             done,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0]    LAST_IDX = IW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] SIGN_BIT = WIDTH'(1) << (WIDTH - 1);

    // Operands must split into whole chunks.
    if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
        $error("comparator_seq: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              eq_q, eq_d;
    logic              lt_q, lt_d;
    logic              gt_q, gt_d;

    // The operand registers shift left by one chunk per step, so the chunk
    // under test always sits at the top. The signed-mode MSB inversion is
    // applied once at capture time; it only ever lands in chunk 0.
    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;

    assign a_chunk = a_q[WIDTH-1 -: CHUNK];
    assign b_chunk = b_q[WIDTH-1 -: CHUNK];

    // State, operand, index and result registers; reset aborts any compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
        end
    end

    // Next-state logic: accept in IDLE, walk chunks in RUN, pulse in DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        gt_d    = gt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = signed_mode ? (a ^ SIGN_BIT) : a;
                    b_d     = signed_mode ? (b ^ SIGN_BIT) : b;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (a_chunk != b_chunk) begin
                    eq_d    = 1'b0;
                    lt_d    = (a_chunk < b_chunk);
                    gt_d    = (a_chunk > b_chunk);
                    state_d = DONE;
                end else if (idx_q == LAST_IDX) begin
                    eq_d    = 1'b1;
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    a_d     = a_q << CHUNK;
                    b_d     = b_q << CHUNK;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready = (state_q == IDLE);
    assign done  = (state_q == DONE);
    assign eq    = eq_q;
    assign lt    = lt_q;
    assign gt    = gt_q;

endmodule

// File: tb/tb_comparator_seq.sv
// Bench for comparator_seq (WIDTH=16, CHUNK=4): directed table, corner sequences, random vs model.
// Inputs driven and outputs sampled on the falling edge.
// All waits for done are bounded by a cycle budget.
module tb_comparator_seq;

    localparam int W   = 16;
    localparam int C   = 4;
    localparam int NCH = W / C;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          signed_mode;
    logic          ready;
    logic          done;
    logic          eq;
    logic          lt;
    logic          gt;

    int n_vec;
    int n_bad;

    // Last result the bench expects the DUT to be holding.
    logic prev_eq, prev_lt, prev_gt;

    comparator_seq #(.WIDTH(W), .CHUNK(C)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .ready       (ready),
        .done        (done),
        .eq          (eq),
        .lt          (lt),
        .gt          (gt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vsm;
        logic         xeq;
        logic         xlt;
        logic         xgt;
        int           xm;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: whole-operand compare with plain arithmetic; m is one plus
    // the position (from the MSB end) of the first differing nibble.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msm,
                                  output logic e, output logic l, output logic g, output int m);
        int sa, sb;
        bit found;
        if (msm) begin
            sa = int'($signed(ma));
            sb = int'($signed(mb));
        end else begin
            sa = int'(ma);
            sb = int'(mb);
        end
        e = (sa == sb);
        l = (sa < sb);
        g = (sa > sb);
        m = NCH;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!found && (((int'(ma) >> (W - C * (i + 1))) & 15) != ((int'(mb) >> (W - C * (i + 1))) & 15))) begin
                m = i + 1;
                found = 1'b1;
            end
        end
    endfunction

    // One full request from a falling edge while ready; ends on a falling edge
    // with the DUT back in IDLE. With disturb set, start is re-pulsed and the
    // operands scrambled during the first two RUN cycles.
    task automatic run_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tsm,
                           input logic e_eq, input logic e_lt, input logic e_gt, input int e_m,
                           input bit disturb, input string nm);
        bit seen;
        int got_m;
        a = ta;
        b = tb_v;
        signed_mode = tsm;
        start = 1'b1;
        check({nm, ".ready_before"}, ready, 1);
        @(posedge clk);
        @(negedge clk);
        seen = 1'b0;
        got_m = 0;
        for (int c = 1; c <= NCH + 2; c++) begin
            if (!seen) begin
                if (disturb && c <= 2) begin
                    start = 1'b1;
                    a = W'($urandom);
                    b = W'($urandom);
                    signed_mode = ~tsm;
                end else begin
                    start = 1'b0;
                end
                check({nm, ".busy"}, ready, 0);
                check({nm, ".hold"}, {eq, lt, gt}, {prev_eq, prev_lt, prev_gt});
                @(posedge clk);
                @(negedge clk);
                if (done) begin
                    seen = 1'b1;
                    got_m = c;
                end
            end
        end
        start = 1'b0;
        if (!seen) begin
            check({nm, ".done_timeout"}, 0, 1);
        end else begin
            check({nm, ".m"}, got_m, e_m);
            check({nm, ".eq"}, eq, e_eq);
            check({nm, ".lt"}, lt, e_lt);
            check({nm, ".gt"}, gt, e_gt);
            check({nm, ".ready_in_done"}, ready, 0);
            prev_eq = e_eq;
            prev_lt = e_lt;
            prev_gt = e_gt;
        end
        @(posedge clk);
        @(negedge clk);
        check({nm, ".done_one_cycle"}, done, 0);
        check({nm, ".ready_after"}, ready, 1);
    endtask

    vec_t tbl[$];

    initial begin
        int cnt_done;
        int cnt_ready;
        logic r_eq, r_lt, r_gt;
        int r_m;
        logic [W-1:0] ra, rb;
        logic rsm;
        int k;

        n_vec = 0;
        n_bad = 0;
        prev_eq = 1'b0;
        prev_lt = 1'b0;
        prev_gt = 1'b0;

        tbl.push_back('{16'hC0FF, 16'hC0FF, 1'b0, 1'b1, 1'b0, 1'b0, 4});
        tbl.push_back('{16'h4000, 16'hC000, 1'b0, 1'b0, 1'b1, 1'b0, 1});
        tbl.push_back('{16'h4000, 16'hC000, 1'b1, 1'b0, 1'b0, 1'b1, 1});
        tbl.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1});
        tbl.push_back('{16'h1235, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 4});
        tbl.push_back('{16'h1204, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 3});
        tbl.push_back('{16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0, 1});
        tbl.push_back('{16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, 1});
        tbl.push_back('{16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 4});
        tbl.push_back('{16'hFFFE, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 4});

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        signed_mode = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.ready", ready, 1);
        check("reset.done", done, 0);
        check("reset.results", {eq, lt, gt}, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table.
        foreach (tbl[i]) begin
            run_cmp(tbl[i].va, tbl[i].vb, tbl[i].vsm, tbl[i].xeq, tbl[i].xlt, tbl[i].xgt,
                    tbl[i].xm, 1'b0, $sformatf("tbl%0d", i));
        end

        // start re-pulsed and operands changed mid-run: result from captured operands only.
        run_cmp(16'h1235, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b1, "disturb");
        cnt_done = 0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            if (done) cnt_done++;
        end
        check("disturb.extra_done", cnt_done, 0);

        // Reset for one cycle mid-run aborts the compare and clears results.
        check("abort.prev_gt", gt, 1);
        a = 16'h1235;
        b = 16'h1234;
        signed_mode = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort.ready", ready, 1);
        check("abort.done", done, 0);
        check("abort.results", {eq, lt, gt}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        prev_eq = 1'b0;
        prev_lt = 1'b0;
        prev_gt = 1'b0;
        cnt_done = 0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            if (done) cnt_done++;
        end
        check("abort.no_done", cnt_done, 0);
        run_cmp(16'h4000, 16'hC000, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, "after_abort");

        // start held high: accepted every IDLE cycle, 3-cycle period for m=1.
        a = 16'h4000;
        b = 16'hC000;
        signed_mode = 1'b1;
        start = 1'b1;
        cnt_done = 0;
        cnt_ready = 0;
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
            if (done) cnt_done++;
            if (ready) cnt_ready++;
        end
        check("b2b.done_count", cnt_done, 3);
        check("b2b.ready_count", cnt_ready, 3);
        check("b2b.gt", gt, 1);
        start = 1'b0;
        repeat (3) @(negedge clk);
        prev_eq = eq;
        prev_lt = lt;
        prev_gt = gt;
        check("b2b.idle_ready", ready, 1);

        // Random operands, biased toward long equal prefixes.
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom);
            k = $urandom_range(0, NCH);
            if (k < NCH) rb = ra ^ (W'($urandom_range(1, 15)) << (W - C * (k + 1)));
            else         rb = ra;
            if ($urandom_range(0, 3) == 0) rb = W'($urandom);
            rsm = 1'($urandom_range(0, 1));
            model(ra, rb, rsm, r_eq, r_lt, r_gt, r_m);
            run_cmp(ra, rb, rsm, r_eq, r_lt, r_gt, r_m, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
